// File: rtl/fc_argmax_classifier.sv
// ---------------------------------------------------------------------------------------------
// fc_argmax_classifier
//
// Streaming argmax stage behind the final fully connected layer. It accepts NUMBER_CLASS
// IEEE-754 binary32 scores, one per accepted beat. It then presents the index and value of the
// largest score on a valid/ready result port. The result is held until the downstream stage
// accepts it.
//
// Parameters:
//   DATA_WIDTH    score width, binary32 (fixed at 32)
//   NUMBER_CLASS  scores per inference, 1..256
//   CLASS_W       derived class-index width, max(1, clog2(NUMBER_CLASS))
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   synchronous reset, active-high
//   i_valid   in   score beat valid
//   i_ready   out  stage can accept a score beat (low while a result is held)
//   i_data    in   score, binary32
//   i_last    in   final score of the inference
//   o_valid   out  result valid, held until o_ready
//   o_ready   in   downstream accepts result
//   o_class   out  index of the maximum score
//   o_score   out  maximum score
//   o_class2  out  runner-up index       (only with ARGMAX_TOP2_EN)
//   o_score2  out  runner-up score       (only with ARGMAX_TOP2_EN)
//   o_err     out  framing error on this result
//
// Optional feature macro: ARGMAX_TOP2_EN adds runner-up tracking and its outputs.
// ---------------------------------------------------------------------------------------------

module fc_argmax_classifier #(
   parameter int unsigned  DATA_WIDTH   = 32,
   parameter int unsigned  NUMBER_CLASS = 2,
   localparam int unsigned CLASS_W      = (NUMBER_CLASS > 1) ? $clog2(NUMBER_CLASS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_valid,
   output logic                  i_ready,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_last,
   output logic                  o_valid,
   input  logic                  o_ready,
   output logic [CLASS_W-1:0]    o_class,
   output logic [DATA_WIDTH-1:0] o_score,
`ifdef ARGMAX_TOP2_EN
   output logic [CLASS_W-1:0]    o_class2,
   output logic [DATA_WIDTH-1:0] o_score2,
`endif
   output logic                  o_err
);

   localparam logic                  SingleClass = (NUMBER_CLASS == 1);
   localparam logic [CLASS_W-1:0]    LastIdx     = CLASS_W'(NUMBER_CLASS - 1);
   localparam logic [CLASS_W-1:0]    OneIdx      = CLASS_W'(1);

   typedef enum logic [1:0] {
      StIdle,
      StScan,
      StHold
   } state_e;

   // Returns 1 when a is strictly greater than b under binary32 ordering.
   // NaN operands: a NaN never wins, and any non-NaN beats a stored NaN.
   // Signed zeros compare equal. Denormals are ordered by raw magnitude bits.
   function automatic logic fp_gt(input logic [DATA_WIDTH-1:0] a,
                                  input logic [DATA_WIDTH-1:0] b);
      logic a_nan;
      logic b_nan;
      logic res;
      a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      if (a_nan) begin
         res = 1'b0;
      end else if (b_nan) begin
         res = 1'b1;
      end else if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) begin
         res = 1'b0;
      end else if (a[31] != b[31]) begin
         res = ~a[31];
      end else if (!a[31]) begin
         res = a[30:0] > b[30:0];
      end else begin
         res = a[30:0] < b[30:0];
      end
      return res;
   endfunction

   state_e                  state_q, state_d;
   logic [CLASS_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   best_q, best_d;
   logic [CLASS_W-1:0]      best_idx_q, best_idx_d;
   logic                    err_q, err_d;
   logic                    beat_acc;
   logic                    beat_gt;

`ifdef ARGMAX_TOP2_EN
   localparam logic [DATA_WIDTH-1:0] NegInf = 32'hFF80_0000;

   logic [DATA_WIDTH-1:0]   second_q, second_d;
   logic [CLASS_W-1:0]      second_idx_q, second_idx_d;
   logic                    beat_gt2;
`endif

   assign i_ready  = (state_q != StHold);
   assign o_valid  = (state_q == StHold);
   assign beat_acc = i_valid && i_ready;
   assign beat_gt  = fp_gt(i_data, best_q);

   assign o_class  = best_idx_q;
   assign o_score  = best_q;
   assign o_err    = err_q;

`ifdef ARGMAX_TOP2_EN
   assign beat_gt2 = fp_gt(i_data, second_q);
   assign o_class2 = second_idx_q;
   assign o_score2 = second_q;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      best_d     = best_q;
      best_idx_d = best_idx_q;
      err_d      = err_q;
`ifdef ARGMAX_TOP2_EN
      second_d     = second_q;
      second_idx_d = second_idx_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (beat_acc) begin
               best_d     = i_data;
               best_idx_d = '0;
               cnt_d      = OneIdx;
               // A lone beat is only well framed when it is also the last one expected.
               err_d      = (i_last != SingleClass);
`ifdef ARGMAX_TOP2_EN
               // Runner-up starts at -Inf so the first real runner-up always displaces it.
               second_d     = NegInf;
               second_idx_d = '0;
`endif
               state_d    = SingleClass ? StHold : StScan;
            end
         end

         StScan: begin
            if (beat_acc) begin
               if (beat_gt) begin
                  best_d     = i_data;
                  best_idx_d = cnt_q;
`ifdef ARGMAX_TOP2_EN
                  second_d     = best_q;
                  second_idx_d = best_idx_q;
`endif
               end
`ifdef ARGMAX_TOP2_EN
               else if (beat_gt2) begin
                  second_d     = i_data;
                  second_idx_d = cnt_q;
               end
`endif
               cnt_d = cnt_q + OneIdx;
               if (cnt_q == LastIdx) begin
                  err_d   = err_q | ~i_last;
                  state_d = StHold;
               end else if (i_last) begin
                  // Short inference: report what arrived, flagged as a framing error.
                  err_d   = 1'b1;
                  state_d = StHold;
               end
            end
         end

         StHold: begin
            if (o_ready) begin
               cnt_d   = '0;
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         best_q     <= '0;
         best_idx_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         best_q     <= best_d;
         best_idx_q <= best_idx_d;
         err_q      <= err_d;
      end
   end

`ifdef ARGMAX_TOP2_EN
   always_ff @(posedge clk) begin
      if (rst_n) begin
         second_q     <= '0;
         second_idx_q <= '0;
      end else begin
         second_q     <= second_d;
         second_idx_q <= second_idx_d;
      end
   end
`endif

endmodule

// File: tb/tb_fc_argmax_classifier.sv
// Directed bench for fc_argmax_classifier. It drives three instances with 4, 3 and 2 classes.
// Each instance has its own valid/ready, and all instances share data/last.
module tb_fc_argmax_classifier;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] data;
   logic        last;

   logic        v4, v3, v2;
   logic        r4, r3, r2;
   logic        ir4, ir3, ir2;
   logic        ov4, ov3, ov2;
   logic [1:0]  c4, c3;
   logic [0:0]  c2;
   logic [31:0] s4, s3, s2;
   logic        e4, e3, e2;
`ifdef ARGMAX_TOP2_EN
   logic [1:0]  c4b, c3b;
   logic [0:0]  c2b;
   logic [31:0] s4b, s3b, s2b;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fc_argmax_classifier #(.DATA_WIDTH(32), .NUMBER_CLASS(4)) u4 (
      .clk(clk), .rst_n(rst_n), .i_valid(v4), .i_ready(ir4), .i_data(data), .i_last(last),
      .o_valid(ov4), .o_ready(r4), .o_class(c4), .o_score(s4),
`ifdef ARGMAX_TOP2_EN
      .o_class2(c4b), .o_score2(s4b),
`endif
      .o_err(e4)
   );

   fc_argmax_classifier #(.DATA_WIDTH(32), .NUMBER_CLASS(3)) u3 (
      .clk(clk), .rst_n(rst_n), .i_valid(v3), .i_ready(ir3), .i_data(data), .i_last(last),
      .o_valid(ov3), .o_ready(r3), .o_class(c3), .o_score(s3),
`ifdef ARGMAX_TOP2_EN
      .o_class2(c3b), .o_score2(s3b),
`endif
      .o_err(e3)
   );

   fc_argmax_classifier #(.DATA_WIDTH(32), .NUMBER_CLASS(2)) u2 (
      .clk(clk), .rst_n(rst_n), .i_valid(v2), .i_ready(ir2), .i_data(data), .i_last(last),
      .o_valid(ov2), .o_ready(r2), .o_class(c2), .o_score(s2),
`ifdef ARGMAX_TOP2_EN
      .o_class2(c2b), .o_score2(s2b),
`endif
      .o_err(e2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Offers one beat to the selected instance for one cycle, after checking it is ready.
   task automatic send(input int u, input logic [31:0] d, input logic l);
      data = d;
      last = l;
      case (u)
         4: begin v4 = 1'b1; chk("ready4_before_beat", 32'(ir4), 32'd1); end
         3: begin v3 = 1'b1; chk("ready3_before_beat", 32'(ir3), 32'd1); end
         default: begin v2 = 1'b1; chk("ready2_before_beat", 32'(ir2), 32'd1); end
      endcase
      step();
      v4 = 1'b0;
      v3 = 1'b0;
      v2 = 1'b0;
      last = 1'b0;
   endtask

   // Checks a held result on the selected instance.
   task automatic res(input int u, input string tag, input int cls, input logic [31:0] sc,
                      input logic err);
      case (u)
         4: begin
            chk({tag, "_valid"}, 32'(ov4), 32'd1);
            chk({tag, "_class"}, 32'(c4), 32'(cls));
            chk({tag, "_score"}, s4, sc);
            chk({tag, "_err"}, 32'(e4), 32'(err));
            chk({tag, "_iready"}, 32'(ir4), 32'd0);
         end
         3: begin
            chk({tag, "_valid"}, 32'(ov3), 32'd1);
            chk({tag, "_class"}, 32'(c3), 32'(cls));
            chk({tag, "_score"}, s3, sc);
            chk({tag, "_err"}, 32'(e3), 32'(err));
         end
         default: begin
            chk({tag, "_valid"}, 32'(ov2), 32'd1);
            chk({tag, "_class"}, 32'(c2), 32'(cls));
            chk({tag, "_score"}, s2, sc);
            chk({tag, "_err"}, 32'(e2), 32'(err));
         end
      endcase
   endtask

   initial begin
      rst_n = 1'b1;
      data  = '0;
      last  = 1'b0;
      {v4, v3, v2} = '0;
      {r4, r3, r2} = 3'b111;
      step();
      step();
      rst_n = 1'b0;

      // Reset state
      chk("rst_valid", 32'(ov4), 32'd0);
      chk("rst_class", 32'(c4), 32'd0);
      chk("rst_score", s4, 32'd0);
      chk("rst_err", 32'(e4), 32'd0);
      chk("rst_iready", 32'(ir4), 32'd1);

      // Basic 4-class inference; result appears the cycle after the last beat
      send(4, 32'h3F80_0000, 1'b0);
      send(4, 32'h4000_0000, 1'b0);
      send(4, 32'hBF80_0000, 1'b0);
      chk("basic_no_early_valid", 32'(ov4), 32'd0);
      send(4, 32'h3FC0_0000, 1'b1);
      res(4, "basic", 1, 32'h4000_0000, 1'b0);
`ifdef ARGMAX_TOP2_EN
      chk("basic_class2", 32'(c4b), 32'd3);
      chk("basic_score2", s4b, 32'h3FC0_0000);
`endif
      step();
      chk("basic_released", 32'(ov4), 32'd0);
      chk("basic_iready_back", 32'(ir4), 32'd1);

      // 2-class: negatives, ties, signed zeros
      send(2, 32'hC000_0000, 1'b0);
      send(2, 32'hBF80_0000, 1'b1);
      res(2, "neg", 1, 32'hBF80_0000, 1'b0);
      step();
      send(2, 32'h4000_0000, 1'b0);
      send(2, 32'h4000_0000, 1'b1);
      res(2, "tie", 0, 32'h4000_0000, 1'b0);
      step();
      send(2, 32'h8000_0000, 1'b0);
      send(2, 32'h0000_0000, 1'b1);
      res(2, "zeros", 0, 32'h8000_0000, 1'b0);
      step();

      // 3-class: NaN handling
      send(3, 32'h7FC0_0000, 1'b0);
      send(3, 32'hBF80_0000, 1'b0);
      send(3, 32'hC000_0000, 1'b1);
      res(3, "nan_first", 1, 32'hBF80_0000, 1'b0);
      step();
      send(3, 32'h3F80_0000, 1'b0);
      send(3, 32'h7FC0_0000, 1'b0);
      send(3, 32'h3F80_0000, 1'b1);
      res(3, "nan_mid", 0, 32'h3F80_0000, 1'b0);
      step();

      // Backpressure: result held for 5 cycles, competing beat offered but not consumed
      r4 = 1'b0;
      send(4, 32'h3F80_0000, 1'b0);
      send(4, 32'hC000_0000, 1'b0);
      send(4, 32'h4100_0000, 1'b0);
      send(4, 32'h4040_0000, 1'b1);
      data = 32'h7F00_0000;
      v4   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         res(4, "hold", 2, 32'h4100_0000, 1'b0);
         step();
      end
      v4 = 1'b0;
      r4 = 1'b1;
      step();
      chk("hold_released", 32'(ov4), 32'd0);
      send(4, 32'hBF80_0000, 1'b0);
      send(4, 32'hBF00_0000, 1'b0);
      send(4, 32'hC040_0000, 1'b0);
      send(4, 32'hC080_0000, 1'b1);
      res(4, "after_hold", 1, 32'hBF00_0000, 1'b0);
      step();

      // Framing: early last, then missing last
      send(4, 32'h3F80_0000, 1'b0);
      send(4, 32'h4040_0000, 1'b1);
      res(4, "early_last", 1, 32'h4040_0000, 1'b1);
      step();
      send(4, 32'h3F80_0000, 1'b0);
      send(4, 32'h40A0_0000, 1'b0);
      send(4, 32'h4000_0000, 1'b0);
      send(4, 32'h3FC0_0000, 1'b0);
      res(4, "missing_last", 1, 32'h40A0_0000, 1'b1);
      step();
      chk("missing_last_released", 32'(ov4), 32'd0);

      // Reset mid-inference discards the partial result
      send(4, 32'h7F00_0000, 1'b0);
      send(4, 32'h7F7F_FFFF, 1'b0);
      rst_n = 1'b1;
      step();
      rst_n = 1'b0;
      chk("midrst_valid", 32'(ov4), 32'd0);
      chk("midrst_score", s4, 32'd0);
      step();
      step();
      chk("midrst_valid_later", 32'(ov4), 32'd0);
      send(4, 32'h3F80_0000, 1'b0);
      send(4, 32'h4000_0000, 1'b0);
      send(4, 32'hBF80_0000, 1'b0);
      send(4, 32'h3FC0_0000, 1'b1);
      res(4, "fresh", 1, 32'h4000_0000, 1'b0);
`ifdef ARGMAX_TOP2_EN
      chk("fresh_class2", 32'(c4b), 32'd3);
      chk("fresh_score2", s4b, 32'h3FC0_0000);
`endif
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fc_argmax_classifier.md
Name: fc_argmax_classifier

Overview:
- Streaming argmax stage directly downstream of the final fully connected layer.
- Consumes the NUMBER_CLASS IEEE-754 single-precision scores of one inference, one score per accepted beat.
- Reports the winning class index and its score through a valid/ready output held until accepted.
- Serves as the classification result interface of the network top.

Parameters:
- DATA_WIDTH, 32, score width; IEEE-754 binary32, fixed at 32.
- NUMBER_CLASS, 2, scores per inference; legal range 1..256.
- CLASS_W, max(1, clog2(NUMBER_CLASS)), width of the class index; derived localparam, not overridable.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-high (asserted = 1)
- i_valid  input  1  score beat valid
- i_ready  output  1  stage can accept a score beat
- i_data  input  DATA_WIDTH  score, binary32
- i_last  input  1  marks final score of an inference
- o_valid  output  1  result valid; held until o_ready
- o_ready  input  1  downstream accepts result
- o_class  output  CLASS_W  index of the maximum score
- o_score  output  DATA_WIDTH  maximum score value
- o_err  output  1  framing error on this result

Behaviour:
- Reset (rst_n=1 at posedge): state IDLE; o_valid=0, o_class=0, o_score=0, o_err=0, beat counter=0; i_ready=1 on the following cycle. Reset mid-inference or while HOLD discards everything; no result is emitted.
- Beat accepted when i_valid & i_ready. i_ready = 1 in IDLE and SCAN, 0 in HOLD (combinational from state).
- IDLE: first accepted beat loads best_score=i_data, best_idx=0, cnt=1, err=(i_last != (NUMBER_CLASS==1)). If NUMBER_CLASS==1, go to HOLD; else go to SCAN.
- SCAN: each accepted beat compares i_data against best_score. Strict greater replaces best_score and sets best_idx=cnt; then cnt++.
  - Beat with cnt==NUMBER_CLASS-1 goes to HOLD. err |= ~i_last.
  - i_last on an earlier beat: err=1 and go to HOLD immediately, with the result computed over the beats received.
- HOLD: o_valid=1; o_class, o_score, o_err are stable. On o_ready go to IDLE with cnt=0; i_ready rises the next cycle.
- Latency: o_valid asserts the cycle after the last beat is accepted. Throughput: NUMBER_CLASS+1 cycles per inference minimum.
- o_ready while o_valid=0 is ignored.
- Compare rules (combinational, binary32 sign-magnitude):
  - Both positive: larger magnitude is greater.
  - Both negative: smaller magnitude is greater.
  - Positive > negative.
  - +0 and -0 compare equal (no replace).
  - NaN (exp=FF, mant!=0) is never greater and never replaces. A NaN first beat is held until any non-NaN replaces it; a non-NaN always beats a stored NaN.
  - +Inf/-Inf are ordered normally.
  - Denormals are compared by raw bits; no flush.
- Ties: the lowest index wins.

Optional Feature:
- Macro ARGMAX_TOP2_EN.
- Defined: adds outputs o_class2 [CLASS_W] and o_score2 [DATA_WIDTH], the runner-up under the same compare and tie rules. When the best is replaced, the old best moves to second; otherwise a beat greater than second replaces second. Runner-up reset value is 0. With NUMBER_CLASS==1, o_class2=0 and o_score2=32'hFF800000 (-Inf).
- Undefined: these ports and their registers do not exist; behaviour is otherwise identical.

Test Plan:
- NUMBER_CLASS=4, beats 3F800000(1.0), 40000000(2.0), BF800000(-1.0), 3FC00000(1.5), i_last on beat 3, o_ready=1 -> o_valid one cycle after beat 3, o_class=1, o_score=40000000, o_err=0.
- NUMBER_CLASS=2, beats C0000000(-2.0), BF800000(-1.0) -> o_class=1, o_score=BF800000. Ties 40000000, 40000000 -> o_class=0. Zeros 80000000, 00000000 -> o_class=0.
- NUMBER_CLASS=3, beats 7FC00000(NaN), BF800000, C0000000 -> o_class=1, o_score=BF800000. Beats 3F800000, 7FC00000, 3F800000 -> o_class=0.
- Backpressure: o_ready=0 for 5 cycles after o_valid -> o_valid, o_class, o_score stable and i_ready=0 throughout; the beat offered during HOLD is not consumed. After o_ready=1, the next inference is accepted and produces the correct result.
- Framing, NUMBER_CLASS=4: i_last on beat 1 -> HOLD after 2 beats with o_err=1. No i_last on beat 3 -> o_err=1 with the correct argmax.
- Reset asserted after 2 of 4 beats -> o_valid stays 0. A fresh 4-beat inference then yields the correct, uncontaminated result. With ARGMAX_TOP2_EN and beats 1.0, 2.0, -1.0, 1.5 -> o_class2=3, o_score2=3FC00000.
